// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target core.
`timescale 1ns/1ps
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_WAIT_STOP
    } i2c_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_target_core_if.sv
// Pad-side and user-side signals of the I2C target; slave = core, master = bus/user environment.
`timescale 1ns/1ps
interface i2c_target_core_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] rd_data;
    logic       rd_load;
    logic       busy;

    modport slave (
        input  scl_i, sda_i, rd_data,
        output sda_oe, rx_data, rx_valid, rd_load, busy
    );

    modport master (
        output scl_i, sda_i, rd_data,
        input  sda_oe, rx_data, rx_valid, rd_load, busy
    );
endinterface

// File: rtl/i2c_sync_edge.sv
// SCL/SDA synchronizers plus one delay flop each; derives bus edges and START/STOP.
`timescale 1ns/1ps
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;

    // Reset to an idle (released) bus so leaving reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl       = scl_sync[SYNC_STAGES-1];
    assign sda       = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl & ~scl_d;
    assign scl_fall  = ~scl & scl_d;
    assign start_det = scl & scl_d & sda_d & ~sda;
    assign stop_det  = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_target_core.sv
// I2C target: single 7-bit address, write bytes out as strobes, read bytes from rd_data.
//
// state        | meaning
// ST_IDLE      | bus free, waiting for START
// ST_ADDR      | shifting address + R/W
// ST_ADDR_ACK  | driving ACK for our address
// ST_WR_BYTE   | receiving a data byte
// ST_WR_ACK    | driving ACK for a received byte
// ST_RD_BYTE   | presenting a data byte, MSB first
// ST_RD_ACK    | sampling controller ACK/NACK
// ST_WAIT_STOP | not addressed / read done, waiting for STOP or START
`timescale 1ns/1ps
module i2c_target_core
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    i2c_target_core_if.slave      bus
);

    logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (bus.scl_i),
        .sda_i     (bus.sda_i),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic       rw, rw_nxt;
    logic       sda_oe, sda_oe_nxt;
    logic [7:0] rx_data, rx_data_nxt;
    logic       rx_valid, rx_valid_nxt;
    logic       rd_load, rd_load_nxt;
    logic       busy, busy_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            shreg    <= '0;
            rw       <= RW_WRITE;
            sda_oe   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rd_load  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            shreg    <= shreg_nxt;
            rw       <= rw_nxt;
            sda_oe   <= sda_oe_nxt;
            rx_data  <= rx_data_nxt;
            rx_valid <= rx_valid_nxt;
            rd_load  <= rd_load_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        shreg_nxt    = shreg;
        rw_nxt       = rw;
        sda_oe_nxt   = sda_oe;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        rd_load_nxt  = 1'b0;
        busy_nxt     = busy;

        if (stop_det) begin
            state_nxt  = ST_IDLE;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else if (start_det) begin
            state_nxt  = ST_ADDR;
            sda_oe_nxt = 1'b0;
            cnt_nxt    = '0;
        end else begin
            unique case (state)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise && cnt != 4'd8) begin
                        shreg_nxt = {shreg[6:0], sda};
                        cnt_nxt   = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        if (shreg[7:1] == ADDR) begin
                            state_nxt  = ST_ADDR_ACK;
                            sda_oe_nxt = 1'b1;
                            busy_nxt   = 1'b1;
                            rw_nxt     = shreg[0];
                        end else begin
                            state_nxt = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_nxt = '0;
                        if (rw == RW_READ) begin
                            state_nxt   = ST_RD_BYTE;
                            shreg_nxt   = bus.rd_data;
                            rd_load_nxt = 1'b1;
                            sda_oe_nxt  = ~bus.rd_data[7];
                        end else begin
                            state_nxt  = ST_WR_BYTE;
                            sda_oe_nxt = 1'b0;
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise && cnt != 4'd8) begin
                        shreg_nxt = {shreg[6:0], sda};
                        cnt_nxt   = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            rx_data_nxt  = {shreg[6:0], sda};
                            rx_valid_nxt = 1'b1;
                        end
                    end else if (scl_fall && cnt == 4'd8) begin
                        state_nxt  = ST_WR_ACK;
                        sda_oe_nxt = 1'b1;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        state_nxt  = ST_WR_BYTE;
                        sda_oe_nxt = 1'b0;
                        cnt_nxt    = '0;
                    end
                end
                // cnt counts bits already handed over; the MSB went out on entry.
                ST_RD_BYTE: begin
                    if (scl_fall) begin
                        if (cnt == 4'd7) begin
                            state_nxt  = ST_RD_ACK;
                            sda_oe_nxt = 1'b0;
                        end else begin
                            shreg_nxt  = {shreg[6:0], 1'b0};
                            sda_oe_nxt = ~shreg[6];
                            cnt_nxt    = cnt + 4'd1;
                        end
                    end
                end
                // A fall here is always preceded by a rise that saw ACK.
                ST_RD_ACK: begin
                    if (scl_rise && sda == I2C_NACK) begin
                        state_nxt = ST_WAIT_STOP;
                    end else if (scl_fall) begin
                        state_nxt   = ST_RD_BYTE;
                        shreg_nxt   = bus.rd_data;
                        rd_load_nxt = 1'b1;
                        sda_oe_nxt  = ~bus.rd_data[7];
                        cnt_nxt     = '0;
                    end
                end
                ST_WAIT_STOP: sda_oe_nxt = 1'b0;
                default: begin
                    state_nxt  = ST_IDLE;
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe   = sda_oe;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.rd_load  = rd_load;
    assign bus.busy     = busy;

endmodule

// File: tb/tb_i2c_target_core.sv
// Bench for i2c_target_core: bit-banged 400 kHz controller with open-drain SDA and scoreboards.
`timescale 1ns/1ps
module tb_i2c_target_core;
    import i2c_pkg::*;

    localparam time Q = 625ns;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl_c = 1'b1;
    logic sda_c = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    int n_rx = 0;
    int n_rd_load = 0;
    int n_oe = 0;
    int rd_idx = 0;

    logic [7:0] rd_tab [0:7] = '{8'hAB, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp_rx [$];
    logic [7:0] exp_rd [$];

    i2c_target_core_if bus ();

    assign bus.scl_i   = scl_c;
    assign bus.sda_i   = sda_c & ~bus.sda_oe;
    assign bus.rd_data = rd_tab[rd_idx[2:0]];

    i2c_target_core #(.ADDR(7'h2A), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #25ns clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rx_valid) begin
                n_rx++;
                if (exp_rx.size() == 0) chk("rx_spurious", 32'(bus.rx_data), 32'hFFFF_FFFF);
                else chk("rx_data", 32'(bus.rx_data), 32'(exp_rx.pop_front()));
            end
            if (bus.rd_load) begin
                n_rd_load++;
                rd_idx++;
            end
            if (bus.rx_valid && bus.rd_load) chk("rx_rd_overlap", 32'd1, 32'd0);
            if (bus.sda_oe) n_oe++;
        end
    end

    task automatic send_bit(input logic b, output logic seen, output logic oe);
        sda_c = b;
        #Q; scl_c = 1'b1;
        #Q; seen = bus.sda_i; oe = bus.sda_oe;
        #Q; scl_c = 1'b0;
        #Q;
    endtask

    task automatic i2c_start();
        sda_c = 1'b1; #Q;
        scl_c = 1'b1; #Q;
        sda_c = 1'b0; #Q;
        scl_c = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_c = 1'b0; #Q;
        scl_c = 1'b1; #Q;
        sda_c = 1'b1; #Q; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s, o;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s, o);
        send_bit(1'b1, ack, o);
    endtask

    task automatic read_byte(input logic ack_out, output logic [7:0] d, output logic oe_ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(1'b1, d[i], oe_ack);
        send_bit(ack_out, s, oe_ack);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack, oe, s;
        logic [7:0] d;
        int rx0, rd0, oe0;

        #1;
        chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("rst_rx_data", 32'(bus.rx_data), 32'h00);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
        #200ns; rst_n = 1'b1;
        #500ns;

        // Single write
        rx0 = n_rx;
        i2c_start();
        write_byte(8'h54, ack); chk("wr_addr_ack", 32'(ack), 32'(I2C_ACK));
        chk("wr_busy", 32'(bus.busy), 32'd1);
        exp_rx.push_back(8'h74);
        write_byte(8'h74, ack); chk("wr_data_ack", 32'(ack), 32'(I2C_ACK));
        i2c_stop();
        chk("wr_rx_count", 32'(n_rx - rx0), 32'd1);
        chk("wr_stop_oe", 32'(bus.sda_oe), 32'd0);
        chk("wr_stop_busy", 32'(bus.busy), 32'd0);

        // Single read with NACK
        rd0 = n_rd_load;
        exp_rd.push_back(8'hAB);
        i2c_start();
        write_byte(8'h55, ack); chk("rd_addr_ack", 32'(ack), 32'(I2C_ACK));
        read_byte(I2C_NACK, d, oe);
        chk("rd_data", 32'(d), 32'(exp_rd.pop_front()));
        chk("rd_nack_oe", 32'(oe), 32'd0);
        i2c_stop();
        chk("rd_load_count", 32'(n_rd_load - rd0), 32'd1);

        // Address mismatch
        rx0 = n_rx; oe0 = n_oe;
        i2c_start();
        write_byte(8'h56, ack); chk("mm_addr_nack", 32'(ack), 32'(I2C_NACK));
        chk("mm_busy", 32'(bus.busy), 32'd0);
        write_byte(8'h11, ack); chk("mm_data_nack", 32'(ack), 32'(I2C_NACK));
        i2c_stop();
        chk("mm_oe_never", 32'(n_oe - oe0), 32'd0);
        chk("mm_rx_count", 32'(n_rx - rx0), 32'd0);

        // Multi-byte write, repeated START, two reads
        rx0 = n_rx; rd0 = n_rd_load;
        i2c_start();
        write_byte(8'h54, ack); chk("mb_addr_ack", 32'(ack), 32'(I2C_ACK));
        exp_rx.push_back(8'h01);
        write_byte(8'h01, ack); chk("mb_d1_ack", 32'(ack), 32'(I2C_ACK));
        exp_rx.push_back(8'h02);
        write_byte(8'h02, ack); chk("mb_d2_ack", 32'(ack), 32'(I2C_ACK));
        i2c_start();
        write_byte(8'h55, ack); chk("mb_raddr_ack", 32'(ack), 32'(I2C_ACK));
        exp_rd.push_back(8'hAB);
        exp_rd.push_back(8'hCD);
        read_byte(I2C_ACK, d, oe);  chk("mb_rd0", 32'(d), 32'(exp_rd.pop_front()));
        read_byte(I2C_NACK, d, oe); chk("mb_rd1", 32'(d), 32'(exp_rd.pop_front()));
        chk("mb_nack_oe", 32'(oe), 32'd0);
        i2c_stop();
        chk("mb_rx_count", 32'(n_rx - rx0), 32'd2);
        chk("mb_rd_load_count", 32'(n_rd_load - rd0), 32'd2);

        // Reset during the 4th data bit of a write
        rx0 = n_rx;
        i2c_start();
        write_byte(8'h54, ack); chk("rs_addr_ack", 32'(ack), 32'(I2C_ACK));
        send_bit(1'b0, s, oe); send_bit(1'b1, s, oe); send_bit(1'b1, s, oe);
        sda_c = 1'b1; #Q; scl_c = 1'b1; #(Q/2);
        chk("rs_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0; #1;
        chk("rs_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("rs_busy", 32'(bus.busy), 32'd0);
        chk("rs_state", 32'(dut.state), 32'(ST_IDLE));
        #200ns; scl_c = 1'b0; #Q; sda_c = 1'b1; #Q; scl_c = 1'b1; #Q;
        rst_n = 1'b1; #500ns;
        chk("rs_rx_none", 32'(n_rx - rx0), 32'd0);
        i2c_start();
        write_byte(8'h54, ack); chk("rs2_addr_ack", 32'(ack), 32'(I2C_ACK));
        exp_rx.push_back(8'h74);
        write_byte(8'h74, ack); chk("rs2_data_ack", 32'(ack), 32'(I2C_ACK));
        i2c_stop();
        chk("rs2_rx_count", 32'(n_rx - rx0), 32'd1);

        // STOP after 5 data bits
        rx0 = n_rx;
        i2c_start();
        write_byte(8'h54, ack); chk("sp_addr_ack", 32'(ack), 32'(I2C_ACK));
        for (int i = 0; i < 5; i++) send_bit(i[0], s, oe);
        i2c_stop();
        chk("sp_rx_none", 32'(n_rx - rx0), 32'd0);
        chk("sp_state", 32'(dut.state), 32'(ST_IDLE));
        chk("sp_busy", 32'(bus.busy), 32'd0);
        i2c_start();
        write_byte(8'h54, ack); chk("sp2_addr_ack", 32'(ack), 32'(I2C_ACK));
        exp_rx.push_back(8'h3C);
        write_byte(8'h3C, ack); chk("sp2_data_ack", 32'(ack), 32'(I2C_ACK));
        i2c_stop();
        chk("sp2_rx_count", 32'(n_rx - rx0), 32'd1);

        #1us;
        chk("rx_queue_left", 32'(exp_rx.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_target_core.md
Name: i2c_target_core

Overview:
- Synthesizable I2C target (slave) for the board-level I2C bus, replacing the behavioural slave model in system-level simulation.
- Oversamples SCL/SDA on a fast system clock and responds to one 7-bit address.
- Delivers written bytes to user logic as strobes.
- Serves read bytes from a user-supplied input.
- SDA is driven open-drain (pull-low enable only); SCL is input-only; no clock stretching.

Parameters:
- ADDR, 7'h2A: 7-bit target address matched after START.
- SYNC_STAGES, 2: flops in the SCL/SDA input synchronizers (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 20x the SCL frequency (8 MHz minimum for 400 kHz).
- rst_n  input  1  asynchronous, active-low reset.
- scl_i  input  1  raw SCL from pad.
- sda_i  input  1  raw SDA from pad.
- sda_oe  output  1  1 = pull SDA low; 0 = release (high via pull-up).
- rx_data  output  8  last byte written by the controller.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- rd_data  input  8  byte to return on the next read byte.
- rd_load  output  1  one-clk pulse when rd_data is captured into the shift register.
- busy  output  1  high from an addressed START until STOP or return to IDLE.

Behaviour:
- Reset values: sda_oe=0, rx_data=8'h00, rx_valid=0, rd_load=0, busy=0, state=IDLE. Synchronizers reset to 1 (idle bus).
- Input conditioning:
  - scl_i and sda_i pass through SYNC_STAGES flops, then one delay flop for edge detection.
  - Events are computed on synchronized signals: scl_rise, scl_fall, START (sda falls while scl high), STOP (sda rises while scl high).
- Sampling and driving:
  - SDA is sampled on scl_rise.
  - sda_oe changes only on scl_fall, except STOP/START/reset, which release it immediately.
  - All data is MSB first.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- IDLE: START -> ADDR with bit counter cleared.
- ADDR: shift 8 bits (7 address + R/W).
  - On the 8th bit, if address == ADDR: next scl_fall -> ADDR_ACK, drive sda_oe=1, busy=1.
  - Otherwise: -> WAIT_STOP with sda released.
- ADDR_ACK: on the following scl_fall, release sda.
  - R/W=0 -> WR_BYTE.
  - R/W=1 -> capture rd_data, pulse rd_load, drive MSB (sda_oe = ~bit) -> RD_BYTE.
- WR_BYTE: shift 8 bits on scl_rise. After the 8th bit: rx_data <= shift register, rx_valid pulses once; next scl_fall -> WR_ACK with sda_oe=1.
- WR_ACK: next scl_fall releases sda -> WR_BYTE. Unlimited bytes per transaction.
- RD_BYTE: on each scl_fall, present the next bit. After the 8th bit's scl_fall, release sda -> RD_ACK.
- RD_ACK: sample the controller's ACK on scl_rise.
  - ACK (0): on scl_fall, load rd_data with an rd_load pulse and drive the MSB -> RD_BYTE.
  - NACK (1): -> WAIT_STOP.
- WAIT_STOP: sda released; waits for STOP or START.
- START in any state (repeated START) -> ADDR, sda released, counter cleared.
- STOP in any state -> IDLE, sda released, busy=0.
- rst_n asserted mid-transfer: immediate release of SDA and return to IDLE; no partial rx_valid.
- A partial byte at STOP is discarded; no rx_valid.
- rx_valid and rd_load never assert in the same cycle.

Decomposition:
- Package i2c_pkg: state enum type, I2C_ACK=1'b0 / I2C_NACK=1'b1 constants, RW_WRITE/RW_READ constants.
- Sub-module i2c_sync_edge: parameterized synchronizer plus delay flop per line, producing scl_rise, scl_fall, start_det, stop_det.
- The core FSM, shift register and counter live in i2c_target_core.

Test Plan:
- Write: START, 0x54 (0x2A,W), 0x74, STOP at 400 kHz -> target ACKs both bytes; rx_data=0x74 with exactly one rx_valid pulse; sda_oe=0 after STOP; busy falls.
- Read: rd_data=8'hAB; START, 0x55 (0x2A,R), controller NACKs, STOP -> address ACKed; controller receives 0xAB; one rd_load pulse; SDA released during the NACK bit.
- Address mismatch: START, 0x56 (0x2B,W), 0x11 -> no ACK on any bit; rx_valid never asserts; busy stays 0.
- Multi-byte and repeated START: write 0x54,0x01,0x02, then repeated START, 0x55, read two bytes (ACK then NACK) with rd_data 0xAB then 0xCD -> rx_valid twice (0x01, 0x02); reads return 0xAB, 0xCD; two rd_load pulses.
- Reset mid-transfer: assert rst_n low during the 4th data bit of a write -> sda_oe=0 immediately, no rx_valid. A following full write of 0x74 succeeds.
- STOP mid-byte: STOP after 5 data bits -> no rx_valid; state IDLE; next transaction is ACKed normally.
